// File: rtl/pixel_array_ctrl_pkg.sv
// Shared types, defaults and Gray-code helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

  localparam int DW_DEFAULT           = 8;
  localparam int ERASE_CYCLES_DEFAULT = 5;
  localparam int READ_CYCLES_DEFAULT  = 2;

  // Widest word the conversion helpers handle. Callers zero-extend a DW-wide
  // value into it and truncate the result back. Leading zeros leave the
  // low DW bits of both conversions unchanged.
  localparam int MAXW = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_TURN,
    S_RD1,
    S_HOLD1,
    S_RD2,
    S_HOLD2
  } ctrl_state_t;

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Valid/ready pixel output channel: one row (two pixels) per transfer.
interface pixel_array_ctrl_if
  import pixel_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic [2*DW-1:0] pix_data;
  logic            pix_row;
  logic            pix_valid;
  logic            pix_ready;

  modport master (
    output pix_data,
    output pix_row,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_row,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/pixel_array_ctrl_gray_ramp_counter.sv
// Binary ramp counter presenting its value Gray-coded, so that consecutive
// bus values differ in exactly one bit. It stops at all-ones and never wraps.
module gray_ramp_counter
  import pixel_ctrl_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  output logic [DW-1:0] data_out,
  output logic          last
);

  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_gray;
  logic          r_last;
  logic [DW-1:0] w_cntNext;

  assign w_cntNext = r_cnt + DW'(1);

  // Gray value and end flag are registered alongside the count so that
  // data_out and last come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_last <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_last <= 1'b0;
    end else if (enable && !r_last) begin
      r_cnt  <= w_cntNext;
      r_gray <= DW'(bin2gray(MAXW'(w_cntNext)));
      r_last <= (w_cntNext == '1);
    end
  end

  assign data_out = r_gray;
  assign last     = r_last;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, Gray ramp convert,
// bus turnaround, then read and hand out each row over valid/ready.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEFAULT,
  parameter int READ_CYCLES  = READ_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DW-1:0]     exposure_time,
  output logic              busy,
  output logic              frame_done,
  output logic              PIX_RESET,
  output logic              ERASE,
  output logic              EXPOSE,
  output logic              CONVERT,
  output logic              READ1,
  output logic              READ2,
  output logic [DW-1:0]     data_out,
  output logic              data_oe,
  input  logic [DW-1:0]     data_in1,
  input  logic [DW-1:0]     data_in2,
  input  logic [DW-1:0]     data_in3,
  input  logic [DW-1:0]     data_in4,
  pixel_array_ctrl_if.master pix
);

  ctrl_state_t     r_state;
  logic [DW-1:0]   r_phase;
  logic [DW-1:0]   r_exposure;
  logic            r_busy;
  logic            r_frameDone;
  logic            r_pixReset;
  logic            r_erase;
  logic            r_expose;
  logic            r_convert;
  logic            r_read1;
  logic            r_read2;
  logic            r_dataOe;
  logic [2*DW-1:0] r_pixData;
  logic            r_pixRow;
  logic            r_pixValid;

  logic            w_rampClear;
  logic            w_rampEnable;
  logic            w_rampLast;
  logic [DW-1:0]   w_rampData;
  logic [DW-1:0]   w_exposeEnd;
  logic            w_eraseEnd;
  logic            w_readEnd;
  logic [2*DW-1:0] w_row1Bin;
  logic [2*DW-1:0] w_row2Bin;

  // The ramp only runs in CONVERT; it is held cleared everywhere else and
  // cleared on the final count so it leaves the bus at zero on exit.
  assign w_rampEnable = (r_state == S_CONVERT) && !w_rampLast;
  assign w_rampClear  = (r_state != S_CONVERT) || w_rampLast;

  gray_ramp_counter #(
    .DW (DW)
  ) u_ramp (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_rampClear),
    .enable   (w_rampEnable),
    .data_out (w_rampData),
    .last     (w_rampLast)
  );

  // A zero exposure still gets one EXPOSE cycle.
  assign w_exposeEnd = (r_exposure == '0) ? '0 : (r_exposure - DW'(1));
  assign w_eraseEnd  = (r_phase == DW'(ERASE_CYCLES - 1));
  assign w_readEnd   = (r_phase == DW'(READ_CYCLES - 1));

  // Pixels hold the Gray code seen when their comparator tripped; hand out binary.
  assign w_row1Bin = {DW'(gray2bin(MAXW'(data_in2))), DW'(gray2bin(MAXW'(data_in1)))};
  assign w_row2Bin = {DW'(gray2bin(MAXW'(data_in4))), DW'(gray2bin(MAXW'(data_in3)))};

  // Frame sequencer: every output is set on the edge that enters its phase,
  // so all control lines are registered and change together with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_exposure  <= '0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_pixReset  <= 1'b0;
      r_erase     <= 1'b0;
      r_expose    <= 1'b0;
      r_convert   <= 1'b0;
      r_read1     <= 1'b0;
      r_read2     <= 1'b0;
      r_dataOe    <= 1'b0;
      r_pixData   <= '0;
      r_pixRow    <= 1'b0;
      r_pixValid  <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exposure <= exposure_time;
            r_phase    <= '0;
            r_busy     <= 1'b1;
            r_erase    <= 1'b1;
            r_pixReset <= 1'b1;
            r_state    <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (w_eraseEnd) begin
            r_erase    <= 1'b0;
            r_pixReset <= 1'b0;
            r_expose   <= 1'b1;
            r_phase    <= '0;
            r_state    <= S_EXPOSE;
          end else begin
            r_phase <= r_phase + DW'(1);
          end
        end
        S_EXPOSE: begin
          if (r_phase == w_exposeEnd) begin
            r_expose  <= 1'b0;
            r_convert <= 1'b1;
            r_dataOe  <= 1'b1;
            r_phase   <= '0;
            r_state   <= S_CONVERT;
          end else begin
            r_phase <= r_phase + DW'(1);
          end
        end
        S_CONVERT: begin
          if (w_rampLast) begin
            r_convert <= 1'b0;
            r_dataOe  <= 1'b0;
            r_state   <= S_TURN;
          end
        end
        S_TURN: begin
          r_read1 <= 1'b1;
          r_phase <= '0;
          r_state <= S_RD1;
        end
        S_RD1: begin
          if (w_readEnd) begin
            r_read1    <= 1'b0;
            r_pixData  <= w_row1Bin;
            r_pixRow   <= 1'b0;
            r_pixValid <= 1'b1;
            r_state    <= S_HOLD1;
          end else begin
            r_phase <= r_phase + DW'(1);
          end
        end
        S_HOLD1: begin
          if (pix.pix_ready) begin
            r_pixValid <= 1'b0;
            r_read2    <= 1'b1;
            r_phase    <= '0;
            r_state    <= S_RD2;
          end
        end
        S_RD2: begin
          if (w_readEnd) begin
            r_read2    <= 1'b0;
            r_pixData  <= w_row2Bin;
            r_pixRow   <= 1'b1;
            r_pixValid <= 1'b1;
            r_state    <= S_HOLD2;
          end else begin
            r_phase <= r_phase + DW'(1);
          end
        end
        S_HOLD2: begin
          if (pix.pix_ready) begin
            r_pixValid  <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_frameDone;
  assign PIX_RESET     = r_pixReset;
  assign ERASE         = r_erase;
  assign EXPOSE        = r_expose;
  assign CONVERT       = r_convert;
  assign READ1         = r_read1;
  assign READ2         = r_read2;
  assign data_out      = w_rampData;
  assign data_oe       = r_dataOe;
  assign pix.pix_data  = r_pixData;
  assign pix.pix_row   = r_pixRow;
  assign pix.pix_valid = r_pixValid;

endmodule
